// File: rtl/arp_decode.sv
// ARP payload decoder: assembles a 56-nibble ARP payload, validates the header and
// reports requests that target this device's IPv4 address.
module arp_decode #(
    parameter logic [47:0] MAC_ADDR = 48'h0,
    parameter logic [31:0] IP_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ivalid,
    input  logic [3:0]  din,
    output logic        req_valid,
    output logic [47:0] sha,
    output logic [31:0] spa,
    output logic        err,
    output logic        busy,
    output logic [47:0] our_mac
);

    localparam int unsigned NIB_W    = 4;
    localparam int unsigned NUM_NIB  = 56;
    localparam int unsigned CAP_W    = NUM_NIB * NIB_W;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned BYTE_W   = 5;
    localparam int unsigned POS_W    = 8;
    localparam int unsigned LAST_BYTE = NUM_NIB / 2 - 1;

    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CAP_W-1:0]  cap, cap_full;
    logic [BYTE_W-1:0] byte_idx;
    logic [POS_W-1:0]  pos;
    logic              ivalid_q;
    logic              cap_en;
    logic              load;
    logic              req_valid_d;
    logic              err_d;
    logic              hdr_ok;
    logic              is_req;
    logic              targeted;

    assign our_mac = MAC_ADDR;

    // Payload is packed MSB-byte first; the low nibble of each byte arrives first.
    assign byte_idx = BYTE_W'(LAST_BYTE) - cnt[CNT_W-1:1];
    assign pos      = {byte_idx, cnt[0], 2'b00};

    // Captured payload with the current nibble merged, so the final nibble can be judged on arrival.
    always_comb begin
        cap_full = cap;
        cap_full[pos +: NIB_W] = din;
    end

    assign hdr_ok   = (cap_full[223:208] == 16'h0001) && (cap_full[207:192] == 16'h0800) &&
                      (cap_full[191:184] == 8'h06)    && (cap_full[183:176] == 8'h04);
    assign is_req   = (cap_full[175:160] == 16'h0001);
    assign targeted = (cap_full[31:0] == IP_ADDR);

    always_comb begin
        state_d     = state;
        cnt_d       = '0;
        cap_en      = 1'b0;
        load        = 1'b0;
        req_valid_d = 1'b0;
        err_d       = 1'b0;
        case (state)
            IDLE: begin
                // A packet already in flight (e.g. across reset) is drained, not decoded.
                if (ivalid) begin
                    if (!ivalid_q) begin
                        cap_en  = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = RECV;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            RECV: begin
                if (!ivalid) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cap_en = 1'b1;
                    cnt_d  = cnt + CNT_W'(1);
                    if (cnt == LAST_NIB) begin
                        state_d = CHECK;
                        if (!hdr_ok) begin
                            err_d = 1'b1;
                        end else if (is_req && targeted) begin
                            req_valid_d = 1'b1;
                            load        = 1'b1;
                        end
                    end
                end
            end
            CHECK: begin
                state_d = ivalid ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!ivalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_valid <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            sha       <= '0;
            spa       <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            req_valid <= req_valid_d;
            err       <= err_d;
            busy      <= (state_d == RECV) || (state_d == DRAIN);
            if (load) begin
                sha <= cap_full[159:112];
                spa <= cap_full[111:80];
            end
        end
    end

    // Capture register is kept apart from sha/spa so partial packets never disturb them.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            cap <= cap_full;
        end
    end

    always_ff @(posedge clk) begin
        ivalid_q <= ivalid;
    end

endmodule
